// File: rtl/data_mem_ctrl.sv
// Single-port data memory behind valid/ready request and response channels,
// with byte-enable writes, programmable wait states and out-of-range error flagging.
module data_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | request latched, counting down wait states; access on cnt==0
  // RESP  | response held until the consumer takes it
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              access;
  logic [IDX_W-1:0]  idx;

  assign in_range  = ({1'b0, lat_addr} < DEPTH_C);
  assign access    = (state == WAIT) && (cnt == 4'd0);
  assign idx       = lat_addr[IDX_W-1:0];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            rsp_err   <= !in_range;
            rsp_rdata <= (in_range && !lat_we) ? mem[idx] : '0;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset before the access edge leaves it untouched
  // because the FSM is forced back to IDLE.
  always_ff @(posedge clk) begin
    if (access && in_range && lat_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (lat_be[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (0, 3 and 5 wait states) checked every
// cycle against a transaction-level model, plus hand-computed directed expectations.
module tb_data_mem_ctrl;

  localparam int WT[3] = '{0, 3, 5};
  localparam int DT[3] = '{1024, 1000, 1024};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [9:0]  req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]));

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]));

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(5)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .busy(busy[2]));

  // Transaction model: in flight flag, cycles since acceptance, result registers, memory image.
  bit          infl [3];
  int          el   [3];
  logic        m_we [3];
  logic [9:0]  m_addr [3];
  logic [31:0] m_wd [3];
  logic [3:0]  m_be [3];
  logic [31:0] m_rd [3];
  logic        m_err [3];
  logic [31:0] mm [3][1024];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d cyc=%0d got=%h expected=%h", nm, k, cyc, act, exp);
    end
  endtask

  // Inputs only change at posedge+1, so the values seen at a negedge are exactly
  // what the following posedge samples; the model is advanced here after checking.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          infl[k] = 1'b0; el[k] = 0; m_rd[k] = '0; m_err[k] = 1'b0;
        end
      end
      for (int k = 0; k < 3; k++) begin
        chk("req_ready", k, 32'(req_ready[k]), 32'(!infl[k]));
        chk("busy",      k, 32'(busy[k]),      32'(infl[k]));
        chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(infl[k] && el[k] >= WT[k] + 1));
        chk("rsp_rdata", k, rsp_rdata[k],      m_rd[k]);
        chk("rsp_err",   k, 32'(rsp_err[k]),   32'(m_err[k]));
      end
      if (rst_n) begin
        for (int k = 0; k < 3; k++) begin
          if (!infl[k]) begin
            if (req_valid[k]) begin
              infl[k] = 1'b1; el[k] = 0;
              m_we[k] = req_we[k]; m_addr[k] = req_addr[k];
              m_wd[k] = req_wdata[k]; m_be[k] = req_be[k];
            end
          end else if (el[k] >= WT[k] + 1) begin
            if (rsp_ready[k]) infl[k] = 1'b0;
          end else begin
            el[k]++;
            if (el[k] == WT[k] + 1) begin
              if (int'(m_addr[k]) >= DT[k]) begin
                m_err[k] = 1'b1; m_rd[k] = '0;
              end else begin
                m_err[k] = 1'b0;
                if (m_we[k]) begin
                  for (int b = 0; b < 4; b++)
                    if (m_be[k][b]) mm[k][m_addr[k]][8*b +: 8] = m_wd[k][8*b +: 8];
                  m_rd[k] = '0;
                end else begin
                  m_rd[k] = mm[k][m_addr[k]];
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic issue(input int k, input logic we, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int acc);
    int n = 0;
    req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_be[k] = be; req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 40) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (!req_ready[k]) begin
      n_fail++;
      $display("FAIL issue_timeout u%0d req_ready got=0 expected=1", k);
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid[k] = 1'b0;
    req_addr[k] = ~a; req_wdata[k] = ~d; req_we[k] = ~we; req_be[k] = ~be;
  endtask

  task automatic get_rsp(input int k, input int hold, input int acc,
                         output logic [31:0] rd, output logic err, output int lat);
    int n = 0;
    while (!rsp_valid[k] && n < 40) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (!rsp_valid[k]) begin
      n_fail++;
      $display("FAIL rsp_timeout u%0d rsp_valid got=0 expected=1", k);
    end
    lat = cyc - acc;
    repeat (hold) begin @(posedge clk); #1; end
    rd = rsp_rdata[k]; err = rsp_err[k];
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
  endtask

  task automatic xfer(input int k, input logic we, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output logic err, output int lat);
    int acc;
    issue(k, we, a, d, be, acc);
    get_rsp(k, 0, acc, rd, err, lat);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat, acc, prev;
    logic [9:0]  alist [6];

    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("reset_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("reset_busy",      0, 32'(busy[0]),      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: write then read back.
    xfer(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, rd, err, lat);
    chk("t1_wr_err",   0, 32'(err), 32'd0);
    chk("t1_wr_rdata", 0, rd, 32'h0);
    xfer(0, 1'b0, 10'd5, 32'h0, 4'h0, rd, err, lat);
    chk("t1_rd_lat",   0, 32'(lat), 32'd1);
    chk("t1_rd_rdata", 0, rd, 32'hDEADBEEF);
    chk("t1_rd_err",   0, 32'(err), 32'd0);

    // Byte enables.
    xfer(0, 1'b1, 10'd7, 32'h11223344, 4'hF, rd, err, lat);
    xfer(0, 1'b1, 10'd7, 32'hAABBCCDD, 4'b0101, rd, err, lat);
    xfer(0, 1'b1, 10'd8, 32'h55555555, 4'h0, rd, err, lat);
    chk("t2_be0_err", 0, 32'(err), 32'd0);
    xfer(0, 1'b0, 10'd7, 32'h0, 4'h0, rd, err, lat);
    chk("t2_rdata", 0, rd, 32'h11BB33DD);

    // Backpressure with a second request waiting; it must only be taken after the handshake.
    issue(0, 1'b0, 10'd5, 32'h0, 4'h0, acc);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'd7; req_be[0] = 4'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 0, 32'(rsp_valid[0]), 32'd1);
      chk("t4_hold_rdata", 0, rsp_rdata[0], 32'hDEADBEEF);
      chk("t4_hold_ready", 0, 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    chk("t4_ready_after", 0, 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    req_valid[0] = 1'b0;
    get_rsp(0, 0, acc, rd, err, lat);
    chk("t4_next_lat",   0, 32'(lat), 32'd1);
    chk("t4_next_rdata", 0, rd, 32'h11BB33DD);

    // Three wait states, DEPTH=1000: out-of-range read and write.
    xfer(1, 1'b1, 10'd999, 32'hCAFEF00D, 4'hF, rd, err, lat);
    chk("t3_wr999_lat", 1, 32'(lat), 32'd4);
    xfer(1, 1'b0, 10'd1000, 32'h0, 4'h0, rd, err, lat);
    chk("t3_rd1000_lat",   1, 32'(lat), 32'd4);
    chk("t3_rd1000_err",   1, 32'(err), 32'd1);
    chk("t3_rd1000_rdata", 1, rd, 32'h0);
    xfer(1, 1'b1, 10'd1001, 32'hFFFFFFFF, 4'hF, rd, err, lat);
    chk("t3_wr1001_err",   1, 32'(err), 32'd1);
    chk("t3_wr1001_rdata", 1, rd, 32'h0);
    xfer(1, 1'b0, 10'd999, 32'h0, 4'h0, rd, err, lat);
    chk("t3_rd999_rdata", 1, rd, 32'hCAFEF00D);
    chk("t3_rd999_err",   1, 32'(err), 32'd0);

    // Reset in the second WAIT cycle of a write must not commit it.
    xfer(2, 1'b1, 10'd3, 32'h12345678, 4'hF, rd, err, lat);
    chk("t5_setup_lat", 2, 32'(lat), 32'd6);
    issue(2, 1'b1, 10'd3, 32'h0, 4'hF, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 2, 32'(req_ready[2]), 32'd1);
    chk("t5_rst_busy",  2, 32'(busy[2]),      32'd0);
    chk("t5_rst_valid", 2, 32'(rsp_valid[2]), 32'd0);
    chk("t5_rst_rdata", 2, rsp_rdata[2],      32'h0);
    chk("t5_rst_err",   2, 32'(rsp_err[2]),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 10'd3, 32'h0, 4'h0, rd, err, lat);
    chk("t5_mem3", 2, rd, 32'h12345678);

    // Back-to-back random traffic on the three-wait-state instance.
    alist = '{10'd20, 10'd21, 10'd22, 10'd23, 10'd1000, 10'd1010};
    for (int i = 0; i < 4; i++) xfer(1, 1'b1, alist[i], 32'hA0A0_0000 + 32'(i), 4'hF, rd, err, lat);
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      issue(1, 1'($urandom_range(0, 1)), alist[$urandom_range(0, 5)], $urandom,
            4'($urandom_range(0, 15)), acc);
      if (prev >= 0) begin
        n_checks++;
        if (acc - prev < WT[1] + 3) begin
          n_fail++;
          $display("FAIL t6_spacing u1 got=%0d expected>=%0d", acc - prev, WT[1] + 3);
        end
      end
      prev = acc;
      get_rsp(1, $urandom_range(0, 3), acc, rd, err, lat);
      chk("t6_lat", 1, 32'(lat), 32'd4);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
